// File: rtl/exec_ctrl_if.sv
// exec_ctrl bus: instruction handshake, ALU drive/return,
// result handshake and architectural condition codes.
interface exec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [31:0] valC;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  alufun;
    logic [31:0] valE;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_valE;
    logic        out_cnd;
    logic        out_err;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC,
        input  valE, out_ready,
        output in_ready, aluA, aluB, alufun,
        output out_valid, out_valE, out_cnd, out_err,
        output cc_zf, cc_sf, cc_of
    );

    modport master (
        output in_valid, icode, ifun, valA, valB, valC,
        output valE, out_ready,
        input  in_ready, aluA, aluB, alufun,
        input  out_valid, out_valE, out_cnd, out_err,
        input  cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/exec_ctrl.sv
// Execute-stage controller: drives the external ALU, waits a
// settle window, captures valE, updates CC and evaluates cnd.
module exec_ctrl #(
    parameter int WORD_BYTES    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input logic        clk,
    input logic        rst_n,
    exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    localparam logic [3:0]  SETTLE = 4'(SETTLE_CYCLES);
    localparam logic [31:0] WB     = 32'(WORD_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [31:0] alua_q, alua_d;
    logic [31:0] alub_q, alub_d;
    logic [3:0]  alufun_q, alufun_d;
    logic [31:0] vale_q, vale_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_cnd_q, out_cnd_d;
    logic        out_err_q, out_err_d;
    logic        zf_q, zf_d;
    logic        sf_q, sf_d;
    logic        of_q, of_d;

    logic [31:0] sel_a, sel_b;
    logic [3:0]  sel_fun;
    logic        is_cond, cond_ok, cond_bad;
    logic        cnd, err, set_cc, new_of;

    // ALU operand/function select from the incoming instruction
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fun = '0;
        case (bus.icode)
            4'h2: sel_a = bus.valA;
            4'h3: sel_a = bus.valC;
            4'h4, 4'h5: begin
                sel_a = bus.valC;
                sel_b = bus.valB;
            end
            4'h6: begin
                sel_a   = bus.valB;
                sel_b   = bus.valA;
                sel_fun = (bus.ifun <= 4'd3) ? bus.ifun : 4'd0;
            end
            4'h8, 4'hA: begin
                sel_a = bus.valB;
                sel_b = -WB;
            end
            4'h9, 4'hB: begin
                sel_a = bus.valB;
                sel_b = WB;
            end
            default: ;
        endcase
    end

    // Condition, error and flag evaluation using pre-update CC
    always_comb begin
        is_cond  = (icode_q == 4'h2) || (icode_q == 4'h7);
        cond_ok  = 1'b0;
        cond_bad = 1'b0;
        case (ifun_q)
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = (sf_q ^ of_q) | zf_q;
            4'd2:    cond_ok = sf_q ^ of_q;
            4'd3:    cond_ok = zf_q;
            4'd4:    cond_ok = !zf_q;
            4'd5:    cond_ok = !(sf_q ^ of_q);
            4'd6:    cond_ok = !(sf_q ^ of_q) && !zf_q;
            default: cond_bad = 1'b1;
        endcase
        cnd    = is_cond & cond_ok;
        set_cc = (icode_q == 4'h6);
        err    = (icode_q >= 4'hC)
               | (set_cc & (ifun_q > 4'd3))
               | (is_cond & cond_bad);
        case (alufun_q)
            4'd0: new_of = (alua_q[31] == alub_q[31])
                         & (bus.valE[31] != alua_q[31]);
            4'd1: new_of = (alua_q[31] != alub_q[31])
                         & (bus.valE[31] != alua_q[31]);
            default: new_of = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE/DRIVE/HOLD sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        alua_d      = alua_q;
        alub_d      = alub_q;
        alufun_d    = alufun_q;
        vale_d      = vale_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_cnd_d   = out_cnd_q;
        out_err_d   = out_err_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    icode_d    = bus.icode;
                    ifun_d     = bus.ifun;
                    alua_d     = sel_a;
                    alub_d     = sel_b;
                    alufun_d   = sel_fun;
                    cnt_d      = SETTLE;
                    in_ready_d = 1'b0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    vale_d      = bus.valE;
                    out_cnd_d   = cnd;
                    out_err_d   = err;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    if (set_cc) begin
                        zf_d = (bus.valE == 32'd0);
                        sf_d = bus.valE[31];
                        of_d = new_of;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            icode_q     <= '0;
            ifun_q      <= '0;
            alua_q      <= '0;
            alub_q      <= '0;
            alufun_q    <= '0;
            vale_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_cnd_q   <= 1'b0;
            out_err_q   <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            alua_q      <= alua_d;
            alub_q      <= alub_d;
            alufun_q    <= alufun_d;
            vale_q      <= vale_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_cnd_q   <= out_cnd_d;
            out_err_q   <= out_err_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.aluA      = alua_q;
    assign bus.aluB      = alub_q;
    assign bus.alufun    = alufun_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_valE  = vale_q;
    assign bus.out_cnd   = out_cnd_q;
    assign bus.out_err   = out_err_q;
    assign bus.cc_zf     = zf_q;
    assign bus.cc_sf     = sf_q;
    assign bus.cc_of     = of_q;
endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Execute-stage controller and initiator for the team's combinational ALU (ports aluA, aluB, alufun, valE).
- Accepts one decoded instruction (icode, ifun, valA, valB, valC) through a valid/ready handshake, selects the ALU operands and function, and holds them stable for a settle window.
- Samples valE, updates the condition codes (ZF, SF, OF), and evaluates the branch/cmov condition.
- Presents the result downstream with a valid/ready handshake.

Parameters:
- WORD_BYTES, 4: stack adjust magnitude. call/push use -WORD_BYTES; ret/pop use +WORD_BYTES.
- SETTLE_CYCLES, 1: cycles ALU inputs are held in DRIVE before valE is sampled. Legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  block can accept.
- icode  in  4  instruction code.
- ifun  in  4  function/condition code.
- valA  in  32  register operand A.
- valB  in  32  register operand B.
- valC  in  32  immediate/displacement.
- aluA  out  32  to ALU.
- aluB  out  32  to ALU.
- alufun  out  4  to ALU: 0 add, 1 sub (aluA-aluB), 2 and, 3 xor.
- valE  in  32  from ALU.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_valE  out  32  captured ALU result.
- out_cnd  out  1  condition result.
- out_err  out  1  illegal icode.
- cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes.

Behaviour:
- Reset (asynchronous, any state): state IDLE. in_ready=1 at exit from reset. out_valid=0, out_valE=0, out_cnd=0, out_err=0. aluA=aluB=0, alufun=0. cc_zf=1, cc_sf=0, cc_of=0.
- States: IDLE, DRIVE, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch all inputs, drive ALU outputs from the latched values, load settle counter with SETTLE_CYCLES, go to DRIVE.
  - ALU outputs otherwise keep their last values.
- DRIVE:
  - in_ready=0. aluA, aluB and alufun are constant.
  - The counter decrements each edge.
  - On the edge where the counter reaches 0: register valE into out_valE, update CC if set_cc, register out_cnd and out_err, set out_valid=1, go to HOLD.
- HOLD:
  - out_valid=1. All outputs are stable. in_valid is ignored.
  - On out_valid&out_ready: out_valid=0, go to IDLE. in_ready is 1 in the following cycle.
- Timing: accept edge to out_valid rising takes SETTLE_CYCLES edges. Minimum initiation interval is SETTLE_CYCLES+2 cycles.
- Operand select (icode hex):
  - 2 rrmov/cmov: aluA=valA, aluB=0, fun=0.
  - 3 irmov: aluA=valC, aluB=0, fun=0.
  - 4 rmmov and 5 mrmov: aluA=valC, aluB=valB, fun=0.
  - 6 OPq: aluA=valB, aluB=valA, fun=ifun. This yields valB OP valA. set_cc=1.
  - 8 call and A push: aluA=valB, aluB=-WORD_BYTES (two's complement), fun=0.
  - 9 ret and B pop: aluA=valB, aluB=WORD_BYTES, fun=0.
  - 0 halt, 1 nop, 7 jXX: aluA=0, aluB=0, fun=0.
  - C..F illegal: aluA=0, aluB=0, fun=0, out_err=1.
  - OPq with ifun>3: fun=0 and out_err=1. CC is still updated from valE.
- CC update (set_cc only):
  - ZF = (valE==0). SF = valE[31].
  - fun 0: OF = (aluA[31]==aluB[31]) & (valE[31]!=aluA[31]).
  - fun 1: OF = (aluA[31]!=aluB[31]) & (valE[31]!=aluA[31]).
  - fun 2/3: OF=0.
- out_cnd (icode 2 or 7 only; all other icodes 0): evaluated from CC values before this instruction.
  - ifun 0: 1. ifun 1: (SF^OF)|ZF. ifun 2: SF^OF. ifun 3: ZF. ifun 4: !ZF. ifun 5: !(SF^OF). ifun 6: !(SF^OF)&!ZF. ifun >6: 0 and out_err=1.
- Arithmetic: 32-bit wrap-around, no carry output.
- Reset asserted mid-DRIVE or mid-HOLD: the instruction is discarded, no CC update persists, all outputs return to reset values.

Test Plan:
- OPq sub: icode=6, ifun=1, valA=0xAA, valB=0xBE, bench ALU = team alu -> aluA=0xBE, aluB=0xAA, alufun=1; out_valE=0x14, ZF=0, SF=0, OF=0; out_valid rises 1 edge after accept.
- Add overflow: icode=6, ifun=0, valA=1, valB=0x7FFFFFFF -> out_valE=0x80000000, ZF=0, SF=1, OF=1. Then icode=6, ifun=1, valA=valB=5 -> out_valE=0, ZF=1, SF=0, OF=0.
- Conditions after ZF=1, SF=0, OF=0:
  - icode=7, ifun=3 -> out_cnd=1.
  - icode=7, ifun=4 -> out_cnd=0.
  - icode=2, ifun=6 -> out_cnd=0.
  - icode=7, ifun=9 -> out_cnd=0, out_err=1.
  - CC unchanged throughout.
- Stack ops: icode=A, valB=0x100 -> aluA=0x100, aluB=0xFFFFFFFC, out_valE=0xFC. icode=9, valB=0xFC -> out_valE=0x100.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_valE, aluA, aluB, alufun stable; in_ready=0; no second accept. Release out_ready -> in_ready=1 next cycle.
- Reset in DRIVE with SETTLE_CYCLES=3 (icode=6, valA=valB=7): assert rst_n=0 mid-DRIVE -> immediately in_ready=1 at release, out_valid=0, aluA=0, alufun=0, ZF=1, SF=0, OF=0.
